// File: rtl/if_stage_ras.sv
// if_stage_ras: parametrised instruction-fetch PC generator.
// It supports sequential, relative, absolute and return next-PC modes.
// It has a return-address stack (RAS) for call/return and a sticky halt state.
//
// Ports:
//   CLK        clock; all state updates on the rising edge
//   Init       synchronous active-high reset; overrides every other input
//   Halt       request to enter HALTED (sticky until Init)
//   Stall      hold PC, RAS and flags for this cycle
//   Branch     next-PC mode: 00 seq, 01 relative, 10 absolute, 11 return
//   Call       with Branch=10, push PC+1 onto the RAS
//   Offset     signed relative displacement
//   Target     absolute jump/call target
//   PC         current fetch address (registered)
//   Halted     high while in HALTED
//   Ras_count  number of valid RAS entries
//   Ras_ovf    sticky: push while RAS full
//   Ras_unf    sticky: return while RAS empty
module if_stage_ras #(
    parameter int unsigned PC_W      = 8,
    parameter int unsigned OFF_W     = 8,
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic                         CLK,
    input  logic                         Init,
    input  logic                         Halt,
    input  logic                         Stall,
    input  logic [1:0]                   Branch,
    input  logic                         Call,
    input  logic [OFF_W-1:0]             Offset,
    input  logic [PC_W-1:0]              Target,
    output logic [PC_W-1:0]              PC,
    output logic                         Halted,
    output logic [$clog2(RAS_DEPTH):0]   Ras_count,
    output logic                         Ras_ovf,
    output logic                         Ras_unf
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    localparam logic [1:0] BR_SEQ = 2'b00;
    localparam logic [1:0] BR_REL = 2'b01;
    localparam logic [1:0] BR_ABS = 2'b10;

    logic [0:0]       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [PC_W-1:0]  ras_mem_q [RAS_DEPTH];

    logic             push_en;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  off_ext;
    logic [PTR_W-1:0] top_m1;
    logic             ras_full;
    logic             ras_empty;

    // top_q points at the next free slot; when full it points at the oldest
    // entry, so a push there naturally overwrites the oldest return address.
    assign pc_inc    = pc_q + PC_W'(1);
    assign off_ext   = PC_W'($signed(Offset));
    assign top_m1    = top_q - PTR_W'(1);
    assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign ras_empty = (cnt_q == CNT_W'(0));

    // Next-state and next-PC decode
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        top_d   = top_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;

        if (state_q == ST_RUN) begin
            if (Halt) begin
                state_d = ST_HALT;
            end else if (!Stall) begin
                case (Branch)
                    BR_SEQ: pc_d = pc_inc;
                    BR_REL: pc_d = pc_q + off_ext;
                    BR_ABS: begin
                        pc_d = Target;
                        if (Call) begin
                            push_en = 1'b1;
                            top_d   = top_q + PTR_W'(1);
                            if (ras_full) begin
                                ovf_d = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        if (!ras_empty) begin
                            pc_d  = ras_mem_q[top_m1];
                            top_d = top_m1;
                            cnt_d = cnt_q - CNT_W'(1);
                        end else begin
                            pc_d  = pc_inc;
                            unf_d = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // State and control registers
    always_ff @(posedge CLK) begin
        if (Init) begin
            state_q <= ST_RUN;
            pc_q    <= PC_W'(RESET_PC);
            top_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            top_q   <= top_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // RAS storage; contents are don't-care after reset
    always_ff @(posedge CLK) begin
        if (!Init && push_en) begin
            ras_mem_q[top_q] <= pc_inc;
        end
    end

    assign PC        = pc_q;
    assign Halted    = (state_q == ST_HALT);
    assign Ras_count = cnt_q;
    assign Ras_ovf   = ovf_q;
    assign Ras_unf   = unf_q;

endmodule

// File: tb/tb_if_stage_ras.sv
// tb_if_stage_ras: directed test-plan steps followed by random stimulus.
// Every step is checked against a queue-based reference model.
module tb_if_stage_ras;

    logic       CLK;
    logic       Init;
    logic       Halt;
    logic       Stall;
    logic [1:0] Branch;
    logic       Call;
    logic [7:0] Offset;
    logic [7:0] Target;
    logic [7:0] PC;
    logic       Halted;
    logic [2:0] Ras_count;
    logic       Ras_ovf;
    logic       Ras_unf;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_pc     = 0;
    bit m_halted = 0;
    bit m_ovf    = 0;
    bit m_unf    = 0;
    int m_ras[$];

    if_stage_ras #(
        .PC_W(8), .OFF_W(8), .RAS_DEPTH(4), .RESET_PC(0)
    ) dut (
        .CLK(CLK), .Init(Init), .Halt(Halt), .Stall(Stall),
        .Branch(Branch), .Call(Call), .Offset(Offset), .Target(Target),
        .PC(PC), .Halted(Halted), .Ras_count(Ras_count),
        .Ras_ovf(Ras_ovf), .Ras_unf(Ras_unf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit i, input bit h, input bit s,
                                input bit [1:0] br, input bit c,
                                input bit [7:0] off, input bit [7:0] tgt);
        int soff;
        if (i) begin
            m_pc = 0; m_halted = 0; m_ovf = 0; m_unf = 0;
            m_ras.delete();
        end else if (m_halted) begin
        end else if (h) begin
            m_halted = 1;
        end else if (!s) begin
            case (br)
                2'd0: m_pc = (m_pc + 1) % 256;
                2'd1: begin
                    soff = (off >= 128) ? int'(off) - 256 : int'(off);
                    m_pc = (m_pc + soff + 256) % 256;
                end
                2'd2: begin
                    if (c) begin
                        if (m_ras.size() == 4) begin
                            m_ovf = 1;
                            void'(m_ras.pop_front());
                        end
                        m_ras.push_back((m_pc + 1) % 256);
                    end
                    m_pc = tgt;
                end
                default: begin
                    if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                    else begin
                        m_pc  = (m_pc + 1) % 256;
                        m_unf = 1;
                    end
                end
            endcase
        end
    endtask

    // Apply one cycle of inputs, advance the model, check all outputs #1 after the edge
    task automatic step(input bit i, input bit h, input bit s, input bit [1:0] br,
                        input bit c, input bit [7:0] off, input bit [7:0] tgt);
        Init = i; Halt = h; Stall = s; Branch = br; Call = c; Offset = off; Target = tgt;
        @(posedge CLK);
        model_update(i, h, s, br, c, off, tgt);
        #1;
        chk("pc",        32'(PC),        32'(m_pc));
        chk("halted",    32'(Halted),    32'(m_halted));
        chk("ras_count", 32'(Ras_count), 32'(m_ras.size()));
        chk("ras_ovf",   32'(Ras_ovf),   32'(m_ovf));
        chk("ras_unf",   32'(Ras_unf),   32'(m_unf));
    endtask

    task automatic jump(input bit [7:0] tgt);
        step(0, 0, 0, 2'd2, 0, 8'h00, tgt);
    endtask

    initial begin
        Init = 1'b1; Halt = 1'b0; Stall = 1'b0; Branch = 2'd0;
        Call = 1'b0; Offset = '0; Target = '0;

        // Reset then sequential fetch
        step(1, 0, 0, 2'd0, 0, 8'h00, 8'h00);
        step(1, 0, 0, 2'd0, 0, 8'h00, 8'h00);
        repeat (4) step(0, 0, 0, 2'd0, 0, 8'h00, 8'h00);
        chk("plan1_pc", 32'(PC), 32'h04);

        // Relative branches and wrap
        jump(8'h10);
        step(0, 0, 0, 2'd1, 0, 8'hFC, 8'h00);
        chk("plan2_back", 32'(PC), 32'h0C);
        jump(8'hFE);
        step(0, 0, 0, 2'd1, 0, 8'h05, 8'h00);
        chk("plan2_wrap", 32'(PC), 32'h03);
        jump(8'hFF);
        step(0, 0, 0, 2'd0, 0, 8'h00, 8'h00);
        chk("plan2_seqwrap", 32'(PC), 32'h00);

        // Call / return
        jump(8'h05);
        step(0, 0, 0, 2'd2, 1, 8'h00, 8'h40);
        repeat (3) step(0, 0, 0, 2'd0, 0, 8'h00, 8'h00);
        step(0, 0, 0, 2'd3, 0, 8'h00, 8'h00);
        chk("plan3_ret", 32'(PC), 32'h06);

        // Overflow then underflow
        for (int k = 0; k < 5; k++) begin
            jump(8'(8'h01 + 8'(k * 16)));
            step(0, 0, 0, 2'd2, 1, 8'h00, 8'h80);
        end
        chk("plan4_ovf", 32'(Ras_ovf), 32'd1);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 2'd3, 0, 8'h00, 8'h00);
        chk("plan4_unf_pc", 32'(PC), 32'h13);

        // Stall suppresses a call, release executes it
        jump(8'h30);
        step(0, 0, 1, 2'd2, 1, 8'h00, 8'h50);
        step(0, 0, 0, 2'd2, 1, 8'h00, 8'h50);
        chk("plan5_call", 32'(Ras_count), 32'd1);

        // Halt is sticky until Init
        jump(8'h20);
        step(0, 1, 0, 2'd2, 0, 8'h00, 8'h80);
        chk("plan6_hold", 32'(PC), 32'h20);
        for (int k = 0; k < 5; k++)
            step(0, 0, 0, 2'($urandom_range(3)), 1'($urandom_range(1)),
                 8'($urandom), 8'($urandom));
        step(1, 0, 0, 2'd0, 0, 8'h00, 8'h00);
        chk("plan6_init", 32'(PC), 32'h00);

        // Random stimulus
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(19) == 0), 1'($urandom_range(39) == 0),
                 1'($urandom_range(4) == 0), 2'($urandom_range(3)),
                 1'($urandom_range(1)), 8'($urandom), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
